// File: rtl/plab4_net_router_input_ctrl_tdm.sv
// Input-port controller for the timing-channel-safe ring router: gates route requests
// by an internal TDM slot schedule over N security domains, with a dead-time guard per slot.
module plab4_net_router_input_ctrl_tdm #(
    parameter int unsigned p_router_id    = 0,
    parameter int unsigned p_num_routers  = 8,
    parameter logic [2:0]  p_default_reqs = 3'b001,
    parameter int unsigned p_num_domains  = 2,
    parameter int unsigned p_slot_cycles  = 4,
    parameter int unsigned p_dead_cycles  = 1,
    parameter int unsigned p_mode         = 0,
    localparam int unsigned c_dest_nbits  = $clog2(p_num_routers),
    localparam int unsigned c_dom_nbits   = (p_num_domains > 1) ? $clog2(p_num_domains) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [c_dest_nbits-1:0] dest,
    input  logic [c_dom_nbits-1:0]  in_domain,
    input  logic                    in_val,
    output logic                    in_rdy,
    output logic [2:0]              reqs,
    input  logic [2:0]              grants,
    output logic [c_dom_nbits-1:0]  cur_domain,
    output logic                    win_open,
    output logic                    slot_miss
);

    // One extra bit so the open-window bound fits even when there is no dead time.
    localparam int unsigned c_slot_nbits  = $clog2(p_slot_cycles + 1);
    localparam int unsigned c_open_cycles = p_slot_cycles - p_dead_cycles;

    localparam logic [c_slot_nbits-1:0] c_last_cnt  = c_slot_nbits'(p_slot_cycles - 1);
    localparam logic [c_slot_nbits-1:0] c_open_cnt  = c_slot_nbits'(c_open_cycles);
    localparam logic [c_slot_nbits-1:0] c_last_open = c_slot_nbits'(c_open_cycles - 1);
    localparam logic [c_dom_nbits-1:0]  c_last_dom  = c_dom_nbits'(p_num_domains - 1);
    localparam logic [c_dest_nbits-1:0] c_local     = c_dest_nbits'(p_router_id);

    typedef enum logic [0:0] {StIdle, StWait} wait_state_e;

    logic [c_slot_nbits-1:0] r_slot_cnt;
    logic [c_dom_nbits-1:0]  r_cur_domain;
    wait_state_e             r_wait_state;
    logic                    r_slot_miss;

    logic [c_slot_nbits-1:0] w_slot_cnt_next;
    logic [c_dom_nbits-1:0]  w_cur_domain_next;
    wait_state_e             w_wait_state_next;
    logic                    w_slot_miss_next;
    logic                    w_last_cnt;
    logic                    w_last_open;
    logic                    w_dom_match;
    logic                    w_eligible;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_slot_cnt   <= '0;
            r_cur_domain <= '0;
            r_wait_state <= StIdle;
            r_slot_miss  <= 1'b0;
        end else begin
            r_slot_cnt   <= w_slot_cnt_next;
            r_cur_domain <= w_cur_domain_next;
            r_wait_state <= w_wait_state_next;
            r_slot_miss  <= w_slot_miss_next;
        end
    end

    always_comb begin
        w_last_cnt        = (r_slot_cnt == c_last_cnt);
        w_last_open       = (r_slot_cnt == c_last_open);
        w_slot_cnt_next   = r_slot_cnt + 1'b1;
        w_cur_domain_next = r_cur_domain;
        if (w_last_cnt) begin
            w_slot_cnt_next   = '0;
            w_cur_domain_next = (r_cur_domain == c_last_dom) ? '0 : r_cur_domain + 1'b1;
        end
    end

    always_comb begin
        win_open    = (r_slot_cnt < c_open_cnt);
        cur_domain  = r_cur_domain;
        slot_miss   = r_slot_miss;
        w_dom_match = (p_mode == 1) || (in_domain == r_cur_domain);
        w_eligible  = in_val & win_open & w_dom_match;
        reqs        = 3'b000;
        if (w_eligible) begin
            reqs = (dest == c_local) ? 3'b010 : p_default_reqs;
        end
        // Nothing is consumed while the controller is held in reset.
        in_rdy = (|(reqs & grants)) & reset;
    end

    // A slot boundary always returns the FSM to idle, overriding any other transition.
    always_comb begin
        w_wait_state_next = r_wait_state;
        unique case (r_wait_state)
            StIdle: if (w_eligible && !in_rdy) w_wait_state_next = StWait;
            StWait: if (in_rdy || w_last_open) w_wait_state_next = StIdle;
            default: w_wait_state_next = StIdle;
        endcase
        if (w_last_cnt) begin
            w_wait_state_next = StIdle;
        end
        w_slot_miss_next = w_last_open & w_eligible & ~in_rdy;
    end

endmodule

// File: doc/plab4_net_router_input_ctrl_tdm.md
Name: plab4_net_router_input_ctrl_tdm

Overview:
Parametrised input-port controller for the timing-channel-safe ring router. It generalises the two-domain enable-gated input control to N security domains. It owns an internal time-division-multiplexed (TDM) slot schedule, so domain gating no longer depends on externally driven enables. Each cycle it decides route requests and input-ready for the single-flit message at one router input. A dead-time guard at the end of every slot stops in-flight traffic leaking across slot boundaries. It sits between the input queue and the switch allocator of each router input port.

Parameters:
p_router_id, 0, id of this router; messages with dest == p_router_id go to the terminal
p_num_routers, 8, routers in ring; sets c_dest_nbits = $clog2(p_num_routers)
p_default_reqs, 3'b001, pass-through request vector for non-local messages
p_num_domains, 2, number of security domains (>=1)
p_slot_cycles, 4, cycles per TDM slot (>=2)
p_dead_cycles, 1, trailing cycles per slot in which no message is accepted (0 <= p_dead_cycles < p_slot_cycles)
p_mode, 0, 0 = TDM gating; 1 = bypass (every domain always eligible, schedule still runs)
c_dom_nbits, max(1,$clog2(p_num_domains)), derived; not set externally

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
dest  in  c_dest_nbits  destination router of head message
in_domain  in  c_dom_nbits  domain tag of head message
in_val  in  1  head message valid
in_rdy  out  1  head message consumed this cycle
reqs  out  3  output-port requests {west?, terminal, default}: bit pattern as p_default_reqs / 3'b010
grants  in  3  grants from switch allocator
cur_domain  out  c_dom_nbits  domain owning current slot
win_open  out  1  current cycle is inside the accept window
slot_miss  out  1  one-cycle pulse: an eligible message waited the whole window without grant

Behaviour:
- Reset (reset==0 at a clk edge): slot_cnt=0, cur_domain=0, wait_flag=0, slot_miss=0. Combinational outputs settle accordingly: win_open=1, reqs=0 unless a matching message is present.
- Reset mid-slot aborts the schedule. No message is consumed in the reset cycle: in_rdy is forced 0 while reset==0.
- Slot counter: slot_cnt increments each cycle. At slot_cnt == p_slot_cycles-1 the next value is 0, and cur_domain advances by 1, wrapping from p_num_domains-1 to 0. With p_num_domains==1, cur_domain stays 0.
- win_open = (slot_cnt < p_slot_cycles - p_dead_cycles). This is combinational from registered state.
- eligible = in_val & win_open & (p_mode==1 | in_domain==cur_domain).
- reqs (combinational): if eligible, then 3'b010 when dest==p_router_id, else p_default_reqs. If not eligible, reqs = 3'b000.
- in_rdy = |(reqs & grants) & reset. Latency is zero: consume happens in the same cycle the grant arrives.
- reqs must drop to 0 in the first dead cycle even if the message was never granted. The message stays in the queue for this domain's next slot.
- wait_flag FSM, two states:
  - IDLE -> WAIT when eligible & !in_rdy.
  - WAIT -> IDLE when in_rdy, or when in the last open cycle.
- slot_miss: registered, asserted for exactly one cycle after the last open cycle of a slot if eligible & !in_rdy held in that cycle. Otherwise 0.
- Simultaneous events: a grant in the last open cycle consumes normally and gives no slot_miss. A slot boundary takes priority over the FSM, so wait_flag returns to IDLE at every new slot.
- Grants arriving while reqs==0 are ignored (in_rdy=0).
- Tag mismatch never produces requests, independent of dest.

Test Plan:
- Reset: hold reset=0 for 3 cycles with in_val=1, in_domain=0, grants=3'b111 -> in_rdy=0, cur_domain=0. After release, slot_cnt counts 0,1,2,3 and then cur_domain=1.
- Local vs. pass-through (defaults, p_router_id=0): in_domain=0, dest=0, slot 0 cycle 0 -> reqs=3'b010. dest=5 -> reqs=3'b001. grants=3'b001 -> in_rdy=1.
- Domain isolation: in_domain=1 during slot 0 -> reqs=0 for cycles 0-3. First request appears at cycle 4 (cur_domain=1).
- Dead time: domain-0 message with grants=0 for the entire slot -> reqs=3'b001 in cycles 0-2, 0 in cycle 3; slot_miss pulses for one cycle in cycle 3 only.
- Boundary grant: grant arrives in cycle 2 (last open cycle) -> in_rdy=1, slot_miss stays 0.
- Bypass (p_mode=1, p_num_domains=4, p_slot_cycles=2, p_dead_cycles=0) -> in_domain=3 requests in every cycle, and cur_domain sequence is 0,0,1,1,2,2,3,3,0.
